instr_fetch_mem: RTL and testbench

Parametrised instruction memory with a valid/ready fetch port, a registered one-cycle response and a side-band program-load port. After reset it fills every word with the ARM NOP (MOV R0,R0, 0xE1A00000) before it accepts fetches. It flags out-of-range and misaligned fetches instead of aliasing them. It sits between the fetch stage (PC → instruction) and the decode stage, replacing the combinational preloaded ROM used up to now.

---
 rtl/instr_mem_pkg.sv | 41 ++++
 rtl/instr_mem_array.sv | 44 ++++
 rtl/instr_fetch_mem.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_mem.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// ---------------------------------------------------------------------------
// instr_mem_pkg
// Shared definitions for the instruction memory (and the future data memory):
//   NOP_WORD_DEFAULT : ARM NOP (MOV R0,R0) used as fill value and fault data
//   fill_state_e     : fill sequencer states {FILL, RUN}
//   addr_info_t      : decoded address (word index + in-range/aligned flags)
//   addr_to_idx()    : converts a byte or word address to a word index
// ---------------------------------------------------------------------------
package instr_mem_pkg;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'hE1A00000;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fill_state_e;

  typedef struct packed {
    logic [31:0] idx;
    logic        in_range;
    logic        aligned;
  } addr_info_t;

  // The range check is done on the full 32-bit word index so that high
  // address bits can never alias onto a valid word.
  function automatic addr_info_t addr_to_idx(input logic [31:0] addr,
                                             input logic        byte_mode,
                                             input logic [31:0] depth);
    addr_info_t info;
    if (byte_mode) begin
      info.idx     = {2'b00, addr[31:2]};
      info.aligned = (addr[1:0] == 2'b00);
    end else begin
      info.idx     = addr;
      info.aligned = 1'b1;
    end
    info.in_range = (info.idx < depth);
    return info;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// ---------------------------------------------------------------------------
// instr_mem_array
// DEPTH x 32 synchronous RAM, one write port and one registered read port.
// A read and a write to the same index in the same cycle returns the new
// data (write-first).
//   clk   : clock, rising edge
//   we    : write enable;  waddr/wdata : write index and data
//   re    : read enable;   raddr       : read index
//   rdata : registered read data, updated only when re = 1
// ---------------------------------------------------------------------------
module instr_mem_array #(
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // No reset on the storage so that it maps onto block RAM; the top refills
  // it with NOPs after every reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      if (we && (waddr == raddr)) begin
        rdata_q <= wdata;
      end else begin
        rdata_q <= mem_q[raddr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// ---------------------------------------------------------------------------
// instr_fetch_mem
// Instruction memory between fetch (PC) and decode. After reset it writes
// NOP_WORD into every word (one per cycle), then serves fetches through a
// valid/ready port with a one-cycle registered response. Out-of-range and
// misaligned fetches return NOP_WORD with rsp_fault set; such loads are
// dropped.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   req_valid/req_ready : fetch handshake, req_addr = PC
//   rsp_valid/rsp_ready : response handshake, rsp_data / rsp_fault
//   ld_en/ld_addr/ld_data : side-band program load (live once init_done)
//   init_done           : NOP fill complete
// ---------------------------------------------------------------------------
module instr_fetch_mem
  import instr_mem_pkg::*;
#(
  parameter int          DEPTH     = 32,
  parameter int          BYTE_ADDR = 1,
  parameter logic [31:0] NOP_WORD  = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_fault,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        init_done
);

  localparam int IDX_W = $clog2(DEPTH);

  fill_state_e      state_q, state_d;
  logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_fault_q, rsp_fault_d;
  // Selects the array output (1) or NOP_WORD (0) for rsp_data; cleared by
  // reset so rsp_data reads NOP_WORD without resetting the RAM.
  logic             use_mem_q, use_mem_d;

  addr_info_t       req_info, ld_info;
  logic             req_ok, ld_ok, accept;
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  logic             unused_idx_bits;

  // Address decode
  always_comb begin
    req_info = addr_to_idx(req_addr, BYTE_ADDR != 0, 32'(DEPTH));
    ld_info  = addr_to_idx(ld_addr,  BYTE_ADDR != 0, 32'(DEPTH));
    req_ok   = req_info.in_range && req_info.aligned;
    ld_ok    = ld_info.in_range && ld_info.aligned;
  end

  // Upper index bits only feed the range check inside addr_to_idx.
  assign unused_idx_bits = ^{req_info.idx[31:IDX_W], ld_info.idx[31:IDX_W]};

  // Fill sequencer and write-port arbitration
  always_comb begin
    state_d    = state_q;
    fill_idx_d = fill_idx_q;
    mem_we     = 1'b0;
    mem_waddr  = fill_idx_q;
    mem_wdata  = NOP_WORD;
    case (state_q)
      FILL: begin
        mem_we     = 1'b1;
        fill_idx_d = fill_idx_q + 1'b1;
        if (fill_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        mem_we    = ld_en && ld_ok;
        mem_waddr = ld_info.idx[IDX_W-1:0];
        mem_wdata = ld_data;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Fetch handshake and response register
  always_comb begin
    init_done   = (state_q == RUN);
    req_ready   = init_done && (!rsp_valid_q || rsp_ready);
    accept      = req_valid && req_ready;
    rsp_valid_d = rsp_valid_q;
    rsp_fault_d = rsp_fault_q;
    use_mem_d   = use_mem_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_fault_d = !req_ok;
      use_mem_d   = req_ok;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      fill_idx_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      use_mem_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_idx_q  <= fill_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      use_mem_q   <= use_mem_d;
    end
  end

  instr_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (accept),
    .raddr (req_info.idx[IDX_W-1:0]),
    .rdata (mem_rdata)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_data  = use_mem_q ? mem_rdata : NOP_WORD;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_mem
// Self-checking bench for instr_fetch_mem (DEPTH = 32, byte addressing).
// ---------------------------------------------------------------------------
module tb_instr_fetch_mem;

  localparam int          DEPTH = 32;
  localparam logic [31:0] NOP   = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_fault;
  logic        ld_en;
  logic [31:0] ld_addr, ld_data;
  logic        init_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  instr_fetch_mem #(
    .DEPTH     (DEPTH),
    .BYTE_ADDR (1),
    .NOP_WORD  (NOP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_fault (rsp_fault),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .init_done (init_done)
  );

  // Reference model: plain word array plus the pending response.
  logic [31:0] model_mem [DEPTH];
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_fault;

  function automatic bit addr_ok(input logic [31:0] a);
    return ((a % 4) == 0) && ((a / 4) < DEPTH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
    m_valid = 1'b0;
    m_data  = NOP;
    m_fault = 1'b0;
  endtask

  task automatic model_load(input logic en, input logic [31:0] a, input logic [31:0] d);
    if (en && addr_ok(a)) model_mem[a / 4] = d;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Waits for init_done with a bound; returns edges counted (0 on timeout).
  task automatic wait_init(output int edges, output bit ready_seen);
    edges      = 0;
    ready_seen = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      if (init_done) begin
        edges = k;
        break;
      end
      if (req_ready) ready_seen = 1'b1;
    end
  endtask

  // One-cycle fetch with rsp_ready held high by the caller.
  task automatic do_fetch(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int          edges;
    bit          ready_seen;
    logic [31:0] held;
    bit          accept;

    vecs[0]  = '{1'b1, 32'h0,        32'hE2807005, 1'b0, 32'h0,        1'b0, NOP,          1'b0};
    vecs[1]  = '{1'b1, 32'h8,        32'hEA000001, 1'b0, 32'h0,        1'b0, NOP,          1'b0};
    vecs[2]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h0,        1'b1, 32'hE2807005, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h4,        1'b1, NOP,          1'b0};
    vecs[4]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h8,        1'b1, 32'hEA000001, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h80,       1'b1, NOP,          1'b1};
    vecs[6]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h6,        1'b1, NOP,          1'b1};
    vecs[7]  = '{1'b1, 32'hC,        32'hE5937004, 1'b1, 32'hC,        1'b1, 32'hE5937004, 1'b0};
    vecs[8]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h80000000, 1'b1, NOP,          1'b1};
    vecs[9]  = '{1'b1, 32'h84,       32'h12345678, 1'b1, 32'h4,        1'b1, NOP,          1'b0};
    vecs[10] = '{1'b1, 32'h11,       32'hDEADBEEF, 1'b1, 32'h10,       1'b1, NOP,          1'b0};
    vecs[11] = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, NOP,          1'b0};
    vecs[12] = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h7C,       1'b1, NOP,          1'b0};
    vecs[13] = '{1'b1, 32'h7C,       32'hAAAA5555, 1'b0, 32'h0,        1'b0, NOP,          1'b0};
    vecs[14] = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h7C,       1'b1, 32'hAAAA5555, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data",  rsp_data,       NOP);
    chk("reset_rsp_fault", 32'(rsp_fault), 32'd0);
    chk("reset_init_done", 32'(init_done), 32'd0);

    // Fill duration
    rst_n = 1'b1;
    wait_init(edges, ready_seen);
    chk("fill_edges", 32'(edges), 32'd32);
    chk("ready_during_fill", 32'(ready_seen), 32'd0);
    $display("fill complete after %0d edges", edges);

    do_fetch(32'h10);
    chk("first_fetch_valid", 32'(rsp_valid), 32'd1);
    chk("first_fetch_data",  rsp_data,       NOP);
    chk("first_fetch_fault", 32'(rsp_fault), 32'd0);
    $display("fetch 00000010 -> %h fault %0d", rsp_data, rsp_fault);

    // Directed vector table, rsp_ready held high
    for (int v = 0; v < 15; v++) begin
      ld_en     = vecs[v].ld_en;
      ld_addr   = vecs[v].ld_addr;
      ld_data   = vecs[v].ld_data;
      req_valid = vecs[v].req_valid;
      req_addr  = vecs[v].req_addr;
      model_load(vecs[v].ld_en, vecs[v].ld_addr, vecs[v].ld_data);
      @(posedge clk); #1;
      ld_en = 1'b0; req_valid = 1'b0;
      chk($sformatf("vec%0d_valid", v), 32'(rsp_valid), 32'(vecs[v].exp_valid));
      if (vecs[v].exp_valid) begin
        chk($sformatf("vec%0d_data", v),  rsp_data,       vecs[v].exp_data);
        chk($sformatf("vec%0d_fault", v), 32'(rsp_fault), 32'(vecs[v].exp_fault));
      end
      $display("vec%0d ld=%0d@%h fetch=%0d@%h -> valid %0d data %h fault %0d",
               v, vecs[v].ld_en, vecs[v].ld_addr, vecs[v].req_valid, vecs[v].req_addr,
               rsp_valid, rsp_data, rsp_fault);
    end
    @(posedge clk); #1;

    // Backpressure: fetch 0x0, stall 3 cycles with a second fetch waiting
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0;
    @(posedge clk); #1;
    req_addr = 32'h8;
    held = rsp_data;
    chk("bp_first_data", rsp_data, 32'hE2807005);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_ready_low%0d", c), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("bp_valid%0d", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp_stable%0d", c), rsp_data, held);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_ready_back", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_next_valid", 32'(rsp_valid), 32'd1);
    chk("bp_next_data",  rsp_data,       32'hEA000001);
    $display("backpressure release fetch 00000008 -> %h", rsp_data);
    @(posedge clk); #1;
    chk("bp_drained", 32'(rsp_valid), 32'd0);

    // Randomised phase against the model
    m_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      ld_en     = ($urandom_range(0, 2) == 0);
      ld_data   = $urandom();
      case ($urandom_range(0, 9))
        7:       req_addr = {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
        8:       req_addr = 32'h80 + 32'($urandom_range(0, 255));
        9:       req_addr = $urandom();
        default: req_addr = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
      endcase
      case ($urandom_range(0, 7))
        6:       ld_addr = {25'd0, 5'($urandom_range(0, 31)), 2'b10};
        7:       ld_addr = $urandom() | 32'h100;
        default: ld_addr = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
      endcase
      #1;
      chk("rnd_req_ready", 32'(req_ready), 32'(!m_valid || rsp_ready));
      accept = req_valid && (!m_valid || rsp_ready);
      model_load(ld_en, ld_addr, ld_data);
      if (accept) begin
        m_valid = 1'b1;
        m_fault = !addr_ok(req_addr);
        m_data  = m_fault ? NOP : model_mem[req_addr / 4];
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk("rnd_rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rnd_rsp_data",  rsp_data,       m_data);
        chk("rnd_rsp_fault", 32'(rsp_fault), 32'(m_fault));
      end
      if (accept)
        $display("rnd fetch %h -> %h fault %0d", req_addr, rsp_data, rsp_fault);
    end
    req_valid = 1'b0; ld_en = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;

    // Reset during a stalled response
    ld_en = 1'b1; ld_addr = 32'h14; ld_data = 32'h11112222;
    @(posedge clk); #1;
    ld_en = 1'b0;
    do_fetch(32'h14);
    chk("pre_rst_load", rsp_data, 32'h11112222);
    req_valid = 1'b1; req_addr = 32'h80;
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    chk("pre_rst_fault", 32'(rsp_fault), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",     32'(rsp_valid), 32'd0);
    chk("mid_rst_fault",     32'(rsp_fault), 32'd0);
    chk("mid_rst_init_done", 32'(init_done), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    $display("reset asserted during stall: valid %0d fault %0d", rsp_valid, rsp_fault);
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = 1'b1;
    wait_init(edges, ready_seen);
    chk("refill_edges", 32'(edges), 32'd32);
    do_fetch(32'h14);
    chk("refill_valid", 32'(rsp_valid), 32'd1);
    chk("refill_data",  rsp_data,       NOP);
    chk("refill_fault", 32'(rsp_fault), 32'd0);
    $display("post-reset fetch 00000014 -> %h", rsp_data);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
